// File: rtl/inout_bus_pkg.sv
// Shared types for the inout bus responder: FSM states, command word layout.
package inout_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        TURN,
        DRIVE,
        RELEASE
    } state_t;

    typedef enum logic {
        CMD_WR = 1'b0,
        CMD_RD = 1'b1
    } cmd_op_t;

    localparam int unsigned MAX_ADDR_W = 8;

    typedef struct packed {
        cmd_op_t               op;
        logic [MAX_ADDR_W-1:0] addr;
    } cmd_t;

    // Read/write flag sits in the MSB of the command word.
    function automatic int unsigned cmd_rd_bit(input int unsigned data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/inout_bus_tristate.sv
// Tri-state pad for the shared bus: the only place high-Z is produced.
module inout_bus_tristate #(
    parameter int unsigned DATA_W = 6
) (
    inout  wire logic [DATA_W-1:0] bus_data,
    input  logic                   oe,
    input  logic [DATA_W-1:0]      drive_val,
    output logic [DATA_W-1:0]      bus_in
);

    assign bus_data = oe ? drive_val : 'z;
    assign bus_in   = bus_data;

endmodule

// File: rtl/inout_bus_responder.sv
// Responder end of a half-duplex strobed bus with a small register file.
// Optional write-data timeout: define INOUT_BUS_RESPONDER_TIMEOUT_EN.
module inout_bus_responder
    import inout_bus_pkg::*;
#(
    parameter int unsigned DATA_W      = 6,
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned TURN_CYC    = 1,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    inout  wire logic [DATA_W-1:0]         bus_data,
    input  logic                           bus_strb,
    output logic                           bus_ack,
    output logic                           busy,
    output logic                           err,
    output logic [(2**ADDR_W)*DATA_W-1:0]  regs_o
);

    localparam int unsigned DEPTH  = 2**ADDR_W;
    localparam int unsigned RD_BIT = cmd_rd_bit(DATA_W);

    state_t              state, state_nxt;
    logic [2:0]          turn_cnt, turn_cnt_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic                wr_ack_q;
    logic                err_q;
    logic [DATA_W-1:0]   bus_in;
    logic                oe;
    cmd_t                cmd;
    logic                load_addr;
    logic                wr_en;
    logic                strb_err;
    logic                tmo_err;
    logic                timeout;
    logic                cmd_unused;

    // Output enable comes straight from the async-reset state, so reset frees the bus at once.
    assign oe = (state == DRIVE);

    inout_bus_tristate #(.DATA_W(DATA_W)) u_tri (
        .bus_data  (bus_data),
        .oe        (oe),
        .drive_val (regs[addr_q]),
        .bus_in    (bus_in)
    );

    always_comb begin
        cmd = '0;
        cmd.op = cmd_op_t'(bus_in[RD_BIT]);
        cmd.addr[ADDR_W-1:0] = bus_in[ADDR_W-1:0];
    end
    assign cmd_unused = ^cmd.addr[MAX_ADDR_W-1:ADDR_W];

`ifdef INOUT_BUS_RESPONDER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 tmo_cnt <= '0;
        else if (state != WDATA) tmo_cnt <= '0;
        else                     tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
    assign timeout = (state == WDATA) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    localparam int unsigned TIMEOUT_CYC_UNUSED = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        turn_cnt_nxt = turn_cnt;
        load_addr    = 1'b0;
        wr_en        = 1'b0;
        strb_err     = 1'b0;
        tmo_err      = 1'b0;
        case (state)
            IDLE: begin
                if (bus_strb) begin
                    load_addr = 1'b1;
                    if (cmd.op == CMD_RD) begin
                        state_nxt    = TURN;
                        turn_cnt_nxt = 3'(TURN_CYC - 1);
                    end else begin
                        state_nxt = WDATA;
                    end
                end
            end
            WDATA: begin
                if (bus_strb) begin
                    wr_en     = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    tmo_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            TURN: begin
                strb_err = bus_strb;
                if (turn_cnt == '0) state_nxt = DRIVE;
                else                turn_cnt_nxt = turn_cnt - 3'd1;
            end
            DRIVE: begin
                strb_err  = bus_strb;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                strb_err  = bus_strb;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            turn_cnt <= '0;
            addr_q   <= '0;
            wr_ack_q <= 1'b0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state    <= state_nxt;
            turn_cnt <= turn_cnt_nxt;
            wr_ack_q <= wr_en;
            if (load_addr)           addr_q       <= cmd.addr[ADDR_W-1:0];
            if (wr_en)               regs[addr_q] <= bus_in;
            if (strb_err || tmo_err) err_q        <= 1'b1;
        end
    end

    assign bus_ack = oe || wr_ack_q;
    assign busy    = (state != IDLE);
    assign err     = err_q;

    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) regs_o[i*DATA_W +: DATA_W] = regs[i];
    end

endmodule

// File: doc/inout_bus_responder.md
Name: inout_bus_responder

Overview:
- Responder (target) end of a half-duplex, tri-stated parallel bus built on a shared inout wire data port plus a strobe line.
- An initiator strobes a command word, then either a write-data word or waits for read data.
- The block holds a small register file.
- It owns bus turnaround: it drives the shared bus only inside a bounded window and releases it deterministically.
- Sits between a bus initiator/testbench master and local configuration logic.

Parameters:
DATA_W, 6, bus/data word width; must be >= ADDR_W+1
ADDR_W, 2, register address width; register file depth = 2**ADDR_W
TURN_CYC, 1, undriven turnaround cycles before responder drives read data (1..7)
TIMEOUT_CYC, 15, max wait for write-data strobe (used only with the optional feature)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
bus_data  inout wire logic  DATA_W  shared data bus; responder drives it only in state DRIVE, otherwise high-Z
bus_strb  input  1  initiator strobe; qualifies bus_data as command or write data
bus_ack  output  1  one-cycle pulse: write accepted / read data valid on bus_data
busy  output  1  high in any state other than IDLE
err  output  1  sticky protocol-error flag
regs_o  output  (2**ADDR_W)*DATA_W  flattened register file; entry i at [i*DATA_W +: DATA_W]

Behaviour:
- Reset (async, any state): state=IDLE, bus_data released to 'z immediately, bus_ack=0, busy=0, err=0, all regs=0, latched addr=0. Mid-read reset must release the bus in the same cycle rst asserts, not at the next edge.
- Command word: bus_data[DATA_W-1] = 1 read / 0 write; bus_data[ADDR_W-1:0] = addr; other bits ignored.
- States: IDLE, WDATA, TURN, DRIVE, RELEASE.
- IDLE:
  - bus_strb=1: latch addr.
  - Write -> WDATA.
  - Read -> TURN with turnaround counter loaded to TURN_CYC-1.
- WDATA:
  - bus_strb=1: regs[addr] <= bus_data, bus_ack=1 in the next cycle, -> IDLE.
  - No strobe: hold.
- TURN: bus undriven; counter decrements; at 0 -> DRIVE.
- DRIVE: bus_data = regs[addr], bus_ack=1 for exactly this one cycle, -> RELEASE.
- RELEASE: bus undriven one cycle, -> IDLE. A new command is accepted no earlier than the cycle after RELEASE.
- Read latency:
  - Command strobed at edge N.
  - Data driven and ack high during cycle N+1+TURN_CYC.
  - Bus free again at N+3+TURN_CYC.
- bus_strb=1 while in TURN, DRIVE or RELEASE:
  - The strobe is ignored.
  - err set (sticky until rst).
  - The FSM sequence is not disturbed.
- Write to regs is visible on regs_o the cycle after acceptance. Read-after-write to the same addr returns the new value.
- Register write and bus_ack are mutually exclusive with DRIVE; at most one ack per transaction.

Optional Feature:
- Macro: INOUT_BUS_RESPONDER_TIMEOUT_EN.
- With the macro: WDATA has a cycle counter (width clog2(TIMEOUT_CYC+1)), cleared on WDATA entry. If TIMEOUT_CYC cycles pass with no strobe:
  - -> IDLE, err=1, no register write, no ack.
- Without the macro: WDATA waits indefinitely, TIMEOUT_CYC is unused, and no counter logic exists.

Decomposition:
- Shared package inout_bus_pkg:
  - state enum (IDLE, WDATA, TURN, DRIVE, RELEASE)
  - CMD_RD_BIT position function/constant
  - typedef for the command word
- One natural sub-module: inout_bus_tristate. It holds the inout wire port, the output-enable and the drive value; all high-Z handling is isolated there.
- Register file and FSM stay in the top.

Test Plan:
- Write then read, TURN_CYC=1: write 6'b000010 (addr 2) then 6'h2A.
  - ack one cycle after the data strobe; regs_o[17:12]=6'h2A.
  - Read cmd 6'b100010 at edge N: bus 'z at N+1, 6'h2A with ack at N+2, 'z at N+3.
- Read every addr after reset: all return 6'h00; bus never driven outside DRIVE (monitor oe every cycle).
- Strobe during TURN:
  - err=1 and stays 1.
  - Read completes with the correct data.
  - No extra ack.
- Reset asserted asynchronously during DRIVE: bus goes 'z, ack=0, state IDLE before the next clock edge; regs cleared.
- TURN_CYC=3: read latency becomes 4 cycles from the command strobe to ack; bus stays 'z for all 3 turnaround cycles.
- With INOUT_BUS_RESPONDER_TIMEOUT_EN, TIMEOUT_CYC=15: write cmd with no data strobe.
  - After 15 cycles: busy=0, err=1, target reg unchanged.
  - Without the macro the FSM is still in WDATA after 100 cycles.
